// File: rtl/round_controller_if.sv
// Bus bundle for round_controller: frame/start/hit inputs and game-flow outputs.
// round_timeout exists only when ROUND_TIMER_EN is defined.
interface round_controller_if #(
  parameter int SCORE_W = 4
);
  logic               frame_vs;
  logic               start;
  logic               player_1_hit;
  logic               player_2_hit;
  logic               freeze;
  logic               respawn;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         winner;
  logic [3:0]         countdown;
  logic [2:0]         state;
`ifdef ROUND_TIMER_EN
  logic               round_timeout;
`endif

  modport slave (
    input  frame_vs, start, player_1_hit, player_2_hit,
    output freeze, respawn, p1_score, p2_score, winner, countdown, state
`ifdef ROUND_TIMER_EN
    , round_timeout
`endif
  );

  modport master (
    output frame_vs, start, player_1_hit, player_2_hit,
    input  freeze, respawn, p1_score, p2_score, winner, countdown, state
`ifdef ROUND_TIMER_EN
    , round_timeout
`endif
  );
endinterface

// File: rtl/round_controller.sv
// Two-player tank game-flow scheduler: start, countdown, play, hit pause, game over.
// Optional PLAY time limit enabled by defining ROUND_TIMER_EN.
module round_controller #(
  parameter int SCORE_W          = 4,
  parameter int WIN_SCORE        = 5,
  parameter int COUNT_DIGITS     = 3,
  parameter int FRAMES_PER_DIGIT = 60,
  parameter int HIT_PAUSE_FRAMES = 90,
  parameter int ROUND_FRAMES     = 1800
) (
  input  logic              Clk,
  input  logic              Reset_n,
  round_controller_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2, S_HP = 3'd3, S_GO = 3'd4
  } state_e;

  // One shared frame timer, sized for the longest interval it ever holds.
  localparam int TMR_MAX0 = (FRAMES_PER_DIGIT > HIT_PAUSE_FRAMES) ? FRAMES_PER_DIGIT : HIT_PAUSE_FRAMES;
  localparam int TMR_MAX  = (TMR_MAX0 > ROUND_FRAMES) ? TMR_MAX0 : ROUND_FRAMES;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]   FPD  = TMR_W'(FRAMES_PER_DIGIT);
  localparam logic [TMR_W-1:0]   HPF  = TMR_W'(HIT_PAUSE_FRAMES);
  localparam logic [TMR_W-1:0]   ONE  = TMR_W'(1);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SMAX = '1;
  localparam logic [3:0]         CDIG = 4'(COUNT_DIGITS);

  state_e             state_q, state_d;
  logic [2:0]         vs_sync_q, vs_sync_d, st_sync_q, st_sync_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d, p1_new, p2_new;
  logic [1:0]         win_q, win_d;
  logic [3:0]         cd_q, cd_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               rsp_q, rsp_d;
  logic               frame_tick, start_edge, tick, any_hit, w1, w2;
`ifdef ROUND_TIMER_EN
  logic [TMR_W-1:0]   rnd_q, rnd_d;
  logic               to_q, to_d;
`endif

  assign vs_sync_d  = {vs_sync_q[1:0], bus.frame_vs};
  assign st_sync_d  = {st_sync_q[1:0], bus.start};
  assign frame_tick = vs_sync_q[1] & ~vs_sync_q[2];
  assign start_edge = st_sync_q[1] & ~st_sync_q[2];
  // A start edge owns its cycle; a coincident frame tick is dropped.
  assign tick       = frame_tick & ~start_edge;
  assign any_hit    = bus.player_1_hit | bus.player_2_hit;

  // P1 being hit scores for P2 and vice versa; scores saturate.
  assign p1_new = (bus.player_2_hit && p1_q != SMAX) ? p1_q + 1'b1 : p1_q;
  assign p2_new = (bus.player_1_hit && p2_q != SMAX) ? p2_q + 1'b1 : p2_q;
  assign w1     = bus.player_2_hit && (p1_new == WIN);
  assign w2     = bus.player_1_hit && (p2_new == WIN);

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    cd_d    = cd_q;
    tmr_d   = tmr_q;
    rsp_d   = 1'b0;
`ifdef ROUND_TIMER_EN
    rnd_d   = rnd_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_GO: begin
        if (start_edge) begin
          p1_d    = '0;
          p2_d    = '0;
          win_d   = 2'b00;
          rsp_d   = 1'b1;
          cd_d    = CDIG;
          tmr_d   = FPD;
          state_d = S_CD;
        end
      end
      S_CD: begin
        if (tick) begin
          if (tmr_q <= ONE) begin
            tmr_d = FPD;
            if (cd_q <= 4'd1) begin
              cd_d    = 4'd0;
              state_d = S_PLAY;
`ifdef ROUND_TIMER_EN
              rnd_d   = TMR_W'(ROUND_FRAMES);
`endif
            end else begin
              cd_d = cd_q - 4'd1;
            end
          end else begin
            tmr_d = tmr_q - ONE;
          end
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (any_hit) begin
            p1_d = p1_new;
            p2_d = p2_new;
            if (w1 || w2) begin
              win_d   = {w2, w1};
              state_d = S_GO;
            end else begin
              tmr_d   = HPF;
              state_d = S_HP;
            end
          end
`ifdef ROUND_TIMER_EN
          else if (rnd_q <= ONE) begin
            to_d    = 1'b1;
            tmr_d   = HPF;
            state_d = S_HP;
          end else begin
            rnd_d = rnd_q - ONE;
          end
`endif
        end
      end
      S_HP: begin
        if (tick) begin
          if (tmr_q <= ONE) begin
            rsp_d   = 1'b1;
            cd_d    = CDIG;
            tmr_d   = FPD;
            state_d = S_CD;
          end else begin
            tmr_d = tmr_q - ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      vs_sync_q <= '0;
      st_sync_q <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      win_q     <= 2'b00;
      cd_q      <= 4'd0;
      tmr_q     <= '0;
      rsp_q     <= 1'b0;
`ifdef ROUND_TIMER_EN
      rnd_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vs_sync_q <= vs_sync_d;
      st_sync_q <= st_sync_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      win_q     <= win_d;
      cd_q      <= cd_d;
      tmr_q     <= tmr_d;
      rsp_q     <= rsp_d;
`ifdef ROUND_TIMER_EN
      rnd_q     <= rnd_d;
      to_q      <= to_d;
`endif
    end
  end

  assign bus.freeze    = (state_q != S_PLAY);
  assign bus.respawn   = rsp_q;
  assign bus.p1_score  = p1_q;
  assign bus.p2_score  = p2_q;
  assign bus.winner    = win_q;
  assign bus.countdown = cd_q;
  assign bus.state     = state_q;
`ifdef ROUND_TIMER_EN
  assign bus.round_timeout = to_q;
`endif
endmodule
